// File: rtl/alu_pwr_pkg.sv
// Shared types and constants for the ALU power-sequencing controller:
// state encoding, dwell-counter width, default dwell lengths and output decode.
package alu_pwr_pkg;

  localparam int PWR_CNT_W          = 8;
  localparam int DEF_PWRUP_CYCLES   = 4;
  localparam int DEF_RESTORE_CYCLES = 2;
  localparam int DEF_SAVE_TIMEOUT   = 8;

  // Code 3'd7 is deliberately left unused; the FSM recovers from it to ON.
  typedef enum logic [2:0] {
    ST_ON      = 3'd0,
    ST_SAVE    = 3'd1,
    ST_ISO     = 3'd2,
    ST_OFF     = 3'd3,
    ST_PWRUP   = 3'd4,
    ST_RESTORE = 3'd5,
    ST_DEISO   = 3'd6
  } pwr_state_e;

  typedef struct packed {
    logic pwr_en;
    logic iso;
    logic save;
    logic restore;
  } pwr_ctl_t;

  // Moore decode of the domain controls for a given state.
  function automatic pwr_ctl_t decode_ctl(input pwr_state_e st);
    pwr_ctl_t ctl;
    ctl = '{pwr_en: 1'b1, iso: 1'b0, save: 1'b0, restore: 1'b0};
    case (st)
      ST_ON:      ctl = '{pwr_en: 1'b1, iso: 1'b0, save: 1'b0, restore: 1'b0};
      ST_SAVE:    ctl = '{pwr_en: 1'b1, iso: 1'b0, save: 1'b1, restore: 1'b0};
      ST_ISO:     ctl = '{pwr_en: 1'b1, iso: 1'b1, save: 1'b0, restore: 1'b0};
      ST_OFF:     ctl = '{pwr_en: 1'b0, iso: 1'b1, save: 1'b0, restore: 1'b0};
      ST_PWRUP:   ctl = '{pwr_en: 1'b1, iso: 1'b1, save: 1'b0, restore: 1'b0};
      ST_RESTORE: ctl = '{pwr_en: 1'b1, iso: 1'b1, save: 1'b0, restore: 1'b1};
      ST_DEISO:   ctl = '{pwr_en: 1'b1, iso: 1'b1, save: 1'b0, restore: 1'b0};
      default:    ctl = '{pwr_en: 1'b1, iso: 1'b0, save: 1'b0, restore: 1'b0};
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/alu_pwr_timer.sv
// Loadable down-counter shared by all dwell states of the power sequencer.
// It saturates at zero; expired is high whenever the count reads zero.
module alu_pwr_timer
  import alu_pwr_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [PWR_CNT_W-1:0] load_val,
  output logic                 expired
);

  logic [PWR_CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/alu_pwr_seq.sv
// Power-sequencing controller for the gated ALU domain (always-on side).
// Optional feature: define ALU_PWR_SEQ_WAKE_ABORT_EN to let wake_req abort a power-down in SAVE/ISO.
module alu_pwr_seq
  import alu_pwr_pkg::*;
#(
  parameter int PWRUP_CYCLES   = DEF_PWRUP_CYCLES,
  parameter int RESTORE_CYCLES = DEF_RESTORE_CYCLES,
  parameter int SAVE_TIMEOUT   = DEF_SAVE_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sleep_req,
  input  logic       wake_req,
  input  logic       alu_busy,
  input  logic       result_valid,
  output logic       alu_pwr_en,
  output logic       iso_en,
  output logic       save,
  output logic       restore,
  output logic       sleep_ack,
  output logic       wake_ack,
  output logic       save_ok,
  output logic [2:0] pwr_state
);

  localparam logic [PWR_CNT_W-1:0] PWRUP_LOAD   = PWR_CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [PWR_CNT_W-1:0] RESTORE_LOAD = PWR_CNT_W'(RESTORE_CYCLES - 1);
  localparam logic [PWR_CNT_W-1:0] SAVE_LOAD    = PWR_CNT_W'(SAVE_TIMEOUT - 1);

  pwr_state_e           state_q;
  pwr_state_e           state_d;
  pwr_ctl_t             ctl_d;
  logic                 tmr_load;
  logic [PWR_CNT_W-1:0] tmr_load_val;
  logic                 tmr_expired;

  // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ON: begin
        if (sleep_req && !alu_busy && !wake_req) state_d = ST_SAVE;
      end
      ST_SAVE: begin
        if (result_valid || tmr_expired) state_d = ST_ISO;
`ifdef ALU_PWR_SEQ_WAKE_ABORT_EN
        if (wake_req) state_d = ST_DEISO;
`endif
      end
      ST_ISO: begin
        state_d = ST_OFF;
`ifdef ALU_PWR_SEQ_WAKE_ABORT_EN
        if (wake_req) state_d = ST_DEISO;
`endif
      end
      ST_OFF: begin
        if (wake_req) state_d = ST_PWRUP;
      end
      ST_PWRUP: begin
        if (tmr_expired) state_d = ST_RESTORE;
      end
      ST_RESTORE: begin
        if (tmr_expired) state_d = ST_DEISO;
      end
      ST_DEISO: state_d = ST_ON;
      default:  state_d = ST_ON;
    endcase
  end

  // The dwell counter is reloaded with N-1 on every state change; 1-cycle states load zero.
  always_comb begin
    tmr_load     = (state_d != state_q);
    tmr_load_val = '0;
    case (state_d)
      ST_SAVE:    tmr_load_val = SAVE_LOAD;
      ST_PWRUP:   tmr_load_val = PWRUP_LOAD;
      ST_RESTORE: tmr_load_val = RESTORE_LOAD;
      default:    tmr_load_val = '0;
    endcase
  end

  alu_pwr_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .expired  (tmr_expired)
  );

  assign ctl_d = decode_ctl(state_d);

  // Outputs are registered from the next state so they switch on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ON;
      alu_pwr_en <= 1'b1;
      iso_en     <= 1'b0;
      save       <= 1'b0;
      restore    <= 1'b0;
      sleep_ack  <= 1'b0;
      wake_ack   <= 1'b0;
      save_ok    <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_pwr_en <= ctl_d.pwr_en;
      iso_en     <= ctl_d.iso;
      save       <= ctl_d.save;
      restore    <= ctl_d.restore;
      sleep_ack  <= (state_d == ST_OFF) && (state_q != ST_OFF);
      wake_ack   <= (state_d == ST_ON) && (state_q == ST_DEISO);
      if (state_q == ST_SAVE && state_d == ST_ISO) save_ok <= result_valid;
    end
  end

  assign pwr_state = state_q;

`ifndef SYNTHESIS
  a_iso_when_off : assert property (@(posedge clk) disable iff (rst) !alu_pwr_en |-> iso_en);
  a_save_restore : assert property (@(posedge clk) disable iff (rst) !(save && restore));
  a_pwr_fall     : assert property (@(posedge clk) disable iff (rst)
                                    $fell(alu_pwr_en) |-> $past(iso_en));
`endif

endmodule

// File: tb/tb_alu_pwr_seq.sv
// Directed self-checking bench for alu_pwr_seq with default dwell parameters.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_alu_pwr_seq;
  import alu_pwr_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       sleep_req, wake_req, alu_busy, result_valid;
  logic       alu_pwr_en, iso_en, save, restore, sleep_ack, wake_ack, save_ok;
  logic [2:0] pwr_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_pwr_seq #(
    .PWRUP_CYCLES   (4),
    .RESTORE_CYCLES (2),
    .SAVE_TIMEOUT   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sleep_req    (sleep_req),
    .wake_req     (wake_req),
    .alu_busy     (alu_busy),
    .result_valid (result_valid),
    .alu_pwr_en   (alu_pwr_en),
    .iso_en       (iso_en),
    .save         (save),
    .restore      (restore),
    .sleep_ack    (sleep_ack),
    .wake_ack     (wake_ack),
    .save_ok      (save_ok),
    .pwr_state    (pwr_state)
  );

  // Vector layout: pwr_en iso save restore sleep_ack wake_ack save_ok state[2:0]
  function automatic logic [9:0] obs();
    return {alu_pwr_en, iso_en, save, restore, sleep_ack, wake_ack, save_ok, pwr_state};
  endfunction

  function automatic logic [9:0] mk(input logic p, input logic i, input logic s, input logic r,
                                    input logic sa, input logic wa, input logic ok,
                                    input logic [2:0] st);
    return {p, i, s, r, sa, wa, ok, st};
  endfunction

  // Domain-level invariants watched on every falling edge outside reset.
  logic prev_pwr = 1'b1;
  logic prev_iso = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if ((!alu_pwr_en && !iso_en) || (save && restore) || (prev_pwr && !alu_pwr_en && !prev_iso)) begin
        n_fail++;
        $display("FAIL invariant: pwr_en=%b iso=%b save=%b restore=%b prev_pwr=%b prev_iso=%b",
                 alu_pwr_en, iso_en, save, restore, prev_pwr, prev_iso);
      end
    end
    prev_pwr <= alu_pwr_en;
    prev_iso <= iso_en;
  end

  task automatic test_reset();
    logic [9:0] exp_v;
    exp_v = mk(1, 0, 0, 0, 0, 0, 0, 3'd0);
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_assert: got %b expected %b", obs(), exp_v);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got %b expected %b", i, obs(), exp_v);
      end
    end
  endtask

  task automatic test_sleep_wake_conflict();
    logic [9:0] exp_v;
    exp_v = mk(1, 0, 0, 0, 0, 0, 0, 3'd0);
    sleep_req = 1'b1;
    wake_req  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL conflict_on[%0d]: got %b expected %b", i, obs(), exp_v);
      end
    end
    sleep_req = 1'b0;
    wake_req  = 1'b0;
  endtask

  task automatic test_sleep_busy();
    logic [9:0] exp_tbl [5];
    sleep_req = 1'b1;
    alu_busy  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== mk(1, 0, 0, 0, 0, 0, 0, 3'd0)) begin
        n_fail++;
        $display("FAIL busy_hold[%0d]: got %b expected %b", i, obs(), mk(1, 0, 0, 0, 0, 0, 0, 3'd0));
      end
    end
    alu_busy = 1'b0;
    exp_tbl = '{mk(1, 0, 1, 0, 0, 0, 0, 3'd1), mk(1, 0, 1, 0, 0, 0, 0, 3'd1),
                mk(1, 1, 0, 0, 0, 0, 1, 3'd2), mk(0, 1, 0, 0, 1, 0, 1, 3'd3),
                mk(0, 1, 0, 0, 0, 0, 1, 3'd3)};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== exp_tbl[i]) begin
        n_fail++;
        $display("FAIL sleep_seq[%0d]: got %b expected %b", i, obs(), exp_tbl[i]);
      end
      if (i == 0) sleep_req = 1'b0;
      if (i == 1) result_valid = 1'b1;
      if (i == 2) result_valid = 1'b0;
    end
  endtask

  task automatic test_wake();
    logic [9:0] exp_tbl [9];
    exp_tbl = '{mk(1, 1, 0, 0, 0, 0, 1, 3'd4), mk(1, 1, 0, 0, 0, 0, 1, 3'd4),
                mk(1, 1, 0, 0, 0, 0, 1, 3'd4), mk(1, 1, 0, 0, 0, 0, 1, 3'd4),
                mk(1, 1, 0, 1, 0, 0, 1, 3'd5), mk(1, 1, 0, 1, 0, 0, 1, 3'd5),
                mk(1, 1, 0, 0, 0, 0, 1, 3'd6), mk(1, 0, 0, 0, 0, 1, 1, 3'd0),
                mk(1, 0, 0, 0, 0, 0, 1, 3'd0)};
    wake_req  = 1'b1;
    sleep_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== exp_tbl[i]) begin
        n_fail++;
        $display("FAIL wake_seq[%0d]: got %b expected %b", i, obs(), exp_tbl[i]);
      end
      if (i == 0) wake_req = 1'b0;
      if (i == 4) sleep_req = 1'b0;
    end
  endtask

  task automatic test_save_timeout();
    logic [9:0] exp_v;
    sleep_req    = 1'b1;
    result_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sleep_req = 1'b0;
      n_checks++;
      if (obs() !== mk(1, 0, 1, 0, 0, 0, 1, 3'd1)) begin
        n_fail++;
        $display("FAIL timeout_save[%0d]: got %b expected %b", i, obs(), mk(1, 0, 1, 0, 0, 0, 1, 3'd1));
      end
    end
    @(negedge clk);
    exp_v = mk(1, 1, 0, 0, 0, 0, 0, 3'd2);
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL timeout_iso: got %b expected %b", obs(), exp_v);
    end
    @(negedge clk);
    exp_v = mk(0, 1, 0, 0, 1, 0, 0, 3'd3);
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL timeout_off: got %b expected %b", obs(), exp_v);
    end
    wake_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wake_req = 1'b0;
    end
    exp_v = mk(1, 0, 0, 0, 0, 1, 0, 3'd0);
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL timeout_rewake: got %b expected %b", obs(), exp_v);
    end
  endtask

  task automatic test_wake_during_iso();
    logic [9:0] exp_v;
    sleep_req    = 1'b1;
    result_valid = 1'b1;
    @(negedge clk);
    sleep_req = 1'b0;
    exp_v = mk(1, 0, 1, 0, 0, 0, 0, 3'd1);
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL wiso_save: got %b expected %b", obs(), exp_v);
    end
    @(negedge clk);
    result_valid = 1'b0;
    wake_req     = 1'b1;
    exp_v = mk(1, 1, 0, 0, 0, 0, 1, 3'd2);
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL wiso_iso: got %b expected %b", obs(), exp_v);
    end
`ifdef ALU_PWR_SEQ_WAKE_ABORT_EN
    @(negedge clk);
    wake_req = 1'b0;
    exp_v = mk(1, 1, 0, 0, 0, 0, 1, 3'd6);
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL wiso_abort_deiso: got %b expected %b", obs(), exp_v);
    end
    @(negedge clk);
    exp_v = mk(1, 0, 0, 0, 0, 1, 1, 3'd0);
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL wiso_abort_on: got %b expected %b", obs(), exp_v);
    end
`else
    @(negedge clk);
    exp_v = mk(0, 1, 0, 0, 1, 0, 1, 3'd3);
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL wiso_off: got %b expected %b", obs(), exp_v);
    end
    @(negedge clk);
    wake_req = 1'b0;
    exp_v = mk(1, 1, 0, 0, 0, 0, 1, 3'd4);
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL wiso_pwrup: got %b expected %b", obs(), exp_v);
    end
    repeat (7) @(negedge clk);
    exp_v = mk(1, 0, 0, 0, 0, 1, 1, 3'd0);
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL wiso_on: got %b expected %b", obs(), exp_v);
    end
`endif
  endtask

  task automatic test_rst_in_restore();
    logic [9:0] exp_v;
    sleep_req    = 1'b1;
    result_valid = 1'b1;
    @(negedge clk);
    sleep_req = 1'b0;
    @(negedge clk);
    result_valid = 1'b0;
    @(negedge clk);
    exp_v = mk(0, 1, 0, 0, 1, 0, 1, 3'd3);
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL min_sleep_off: got %b expected %b", obs(), exp_v);
    end
    wake_req = 1'b1;
    @(negedge clk);
    wake_req = 1'b0;
    repeat (4) @(negedge clk);
    exp_v = mk(1, 1, 0, 1, 0, 0, 1, 3'd5);
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL rst_pre_restore: got %b expected %b", obs(), exp_v);
    end
    #2;
    rst = 1'b1;
    #1;
    exp_v = mk(1, 0, 0, 0, 0, 0, 0, 3'd0);
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL rst_async: got %b expected %b", obs(), exp_v);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL rst_release: got %b expected %b", obs(), exp_v);
    end
  endtask

  initial begin
    rst          = 1'b1;
    sleep_req    = 1'b0;
    wake_req     = 1'b0;
    alu_busy     = 1'b0;
    result_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_sleep_wake_conflict();
    test_sleep_busy();
    test_wake();
    test_save_timeout();
    test_wake_during_iso();
    test_rst_in_restore();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
